// File: rtl/pit_programmer.sv
// pit_programmer: host-side sequencer for the mini programmable interval timer.
//
// Takes one timer command over a valid/ready handshake. It holds the PIT in reset,
// then writes the config byte, the count high byte and the count low byte. Next it
// waits for the PIT to report that the count is loaded. After that it watches the PIT
// interrupt line: it counts rising edges and measures the number of cycles between
// them. Every output is a flop.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   cmd_valid/ready     command handshake (ready only while idle)
//   cmd_divider/repeat  PIT mode bits
//   cmd_count           PIT terminal count
//   cmd_irqs            edges to collect before finishing, 0 = until stop
//   stop                abort the running command
//   pit_rst_n           PIT reset, active low
//   cfg_data/we/addr    PIT config bus (00 config, 01 count hi, 10 count lo)
//   pit_counter_set     PIT status: count loaded
//   pit_irq             PIT interrupt line
//   busy, done, error   status; done pulses on every return to idle
//   irq_count           interrupt edges seen, saturating
//   last_period         cycles between the two most recent edges
module pit_programmer #(
    parameter int unsigned RST_CYCLES  = 2,
    parameter int unsigned SET_TIMEOUT = 15,
    parameter int unsigned PERIOD_W    = 24
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_divider,
    input  logic                cmd_repeat,
    input  logic [15:0]         cmd_count,
    input  logic [7:0]          cmd_irqs,
    input  logic                stop,
    output logic                pit_rst_n,
    output logic [7:0]          cfg_data,
    output logic                cfg_we,
    output logic [1:0]          cfg_addr,
    input  logic                pit_counter_set,
    input  logic                pit_irq,
    output logic                busy,
    output logic                done,
    output logic                error,
    output logic [7:0]          irq_count,
    output logic [PERIOD_W-1:0] last_period
);

    localparam int unsigned RST_W  = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam int unsigned WAIT_W = (SET_TIMEOUT > 1) ? $clog2(SET_TIMEOUT) : 1;
    localparam logic [RST_W-1:0]  RST_LAST  = RST_W'(RST_CYCLES - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(SET_TIMEOUT - 1);

    typedef enum logic [2:0] {
        StIdle, StPrst, StWrCfg, StWrHi, StWrLo, StWaitSet, StMonitor
    } state_e;

    state_e              state;
    logic [RST_W-1:0]    rst_cnt;
    logic [WAIT_W-1:0]   wait_cnt;
    logic [PERIOD_W-1:0] period_cnt;
    logic                irq_prev;
    logic                divider_q;
    logic                repeat_q;
    logic [15:0]         count_q;
    logic [7:0]          irqs_q;

    logic                irq_edge;
    logic [7:0]          irq_next;
    logic [PERIOD_W-1:0] period_inc;

    always_comb begin
        irq_edge   = pit_irq & ~irq_prev;
        irq_next   = (irq_count == 8'hFF) ? 8'hFF : irq_count + 8'd1;
        period_inc = (&period_cnt) ? period_cnt : period_cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= StIdle;
            cmd_ready   <= 1'b0;
            pit_rst_n   <= 1'b0;
            cfg_data    <= 8'h00;
            cfg_we      <= 1'b0;
            cfg_addr    <= 2'b00;
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
            irq_count   <= 8'h00;
            last_period <= '0;
            rst_cnt     <= '0;
            wait_cnt    <= '0;
            period_cnt  <= '0;
            irq_prev    <= 1'b0;
            divider_q   <= 1'b0;
            repeat_q    <= 1'b0;
            count_q     <= 16'h0000;
            irqs_q      <= 8'h00;
        end else begin
            done <= 1'b0;
            unique case (state)
                StIdle: begin
                    cmd_ready <= 1'b1;
                    busy      <= 1'b0;
                    pit_rst_n <= 1'b1;
                    cfg_we    <= 1'b0;
                    cfg_addr  <= 2'b00;
                    cfg_data  <= 8'h00;
                    if (cmd_valid && cmd_ready) begin
                        divider_q   <= cmd_divider;
                        repeat_q    <= cmd_repeat;
                        count_q     <= cmd_count;
                        irqs_q      <= cmd_irqs;
                        irq_count   <= 8'h00;
                        last_period <= '0;
                        error       <= 1'b0;
                        rst_cnt     <= '0;
                        pit_rst_n   <= 1'b0;
                        cmd_ready   <= 1'b0;
                        busy        <= 1'b1;
                        state       <= StPrst;
                    end
                end
                StPrst: begin
                    if (rst_cnt == RST_LAST) begin
                        pit_rst_n <= 1'b1;
                        cfg_we    <= 1'b1;
                        cfg_addr  <= 2'b00;
                        cfg_data  <= {divider_q, repeat_q, 6'b000000};
                        state     <= StWrCfg;
                    end else begin
                        rst_cnt <= rst_cnt + 1'b1;
                    end
                end
                StWrCfg: begin
                    cfg_addr <= 2'b01;
                    cfg_data <= count_q[15:8];
                    state    <= StWrHi;
                end
                StWrHi: begin
                    cfg_addr <= 2'b10;
                    cfg_data <= count_q[7:0];
                    state    <= StWrLo;
                end
                StWrLo: begin
                    cfg_we   <= 1'b0;
                    cfg_addr <= 2'b00;
                    cfg_data <= 8'h00;
                    wait_cnt <= '0;
                    state    <= StWaitSet;
                end
                StWaitSet: begin
                    // A set seen in the last allowed cycle still wins over the timeout.
                    if (pit_counter_set) begin
                        period_cnt <= '0;
                        irq_prev   <= 1'b0;
                        state      <= StMonitor;
                    end else if (wait_cnt == WAIT_LAST) begin
                        error     <= 1'b1;
                        done      <= 1'b1;
                        cmd_ready <= 1'b1;
                        busy      <= 1'b0;
                        state     <= StIdle;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                StMonitor: begin
                    irq_prev <= pit_irq;
                    if (irq_edge) begin
                        last_period <= period_inc;
                        period_cnt  <= '0;
                        irq_count   <= irq_next;
                        if (irqs_q != 8'h00 && irq_next == irqs_q) begin
                            done      <= 1'b1;
                            cmd_ready <= 1'b1;
                            busy      <= 1'b0;
                            state     <= StIdle;
                        end
                    end else begin
                        period_cnt <= period_inc;
                    end
                end
                default: state <= StIdle;
            endcase

            // Abort overrides the next state only; an edge seen this cycle is still counted
            // above, and done is a single pulse either way.
            if (stop && state != StIdle) begin
                state     <= StIdle;
                done      <= 1'b1;
                cmd_ready <= 1'b1;
                busy      <= 1'b0;
                pit_rst_n <= 1'b1;
                cfg_we    <= 1'b0;
                cfg_addr  <= 2'b00;
                cfg_data  <= 8'h00;
            end
        end
    end

endmodule

// File: tb/tb_pit_programmer.sv
// Bench for pit_programmer. A table of commands runs against a small PIT model.
// A scoreboard checks the config-bus writes, and hand-written sequences cover
// reset, stop, saturation and reset in the middle of a write.
module tb_pit_programmer;

    localparam int unsigned RST_CYCLES  = 2;
    localparam int unsigned SET_TIMEOUT = 15;
    localparam int unsigned PERIOD_W    = 24;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                cmd_valid;
    logic                cmd_ready;
    logic                cmd_divider;
    logic                cmd_repeat;
    logic [15:0]         cmd_count;
    logic [7:0]          cmd_irqs;
    logic                stop;
    logic                pit_rst_n;
    logic [7:0]          cfg_data;
    logic                cfg_we;
    logic [1:0]          cfg_addr;
    logic                pit_counter_set;
    logic                pit_irq;
    logic                busy;
    logic                done;
    logic                error;
    logic [7:0]          irq_count;
    logic [PERIOD_W-1:0] last_period;

    always #5 clk = ~clk;

    pit_programmer #(
        .RST_CYCLES  (RST_CYCLES),
        .SET_TIMEOUT (SET_TIMEOUT),
        .PERIOD_W    (PERIOD_W)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_divider     (cmd_divider),
        .cmd_repeat      (cmd_repeat),
        .cmd_count       (cmd_count),
        .cmd_irqs        (cmd_irqs),
        .stop            (stop),
        .pit_rst_n       (pit_rst_n),
        .cfg_data        (cfg_data),
        .cfg_we          (cfg_we),
        .cfg_addr        (cfg_addr),
        .pit_counter_set (pit_counter_set),
        .pit_irq         (pit_irq),
        .busy            (busy),
        .done            (done),
        .error           (error),
        .irq_count       (irq_count),
        .last_period     (last_period)
    );

    int checks = 0;
    int passed = 0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    endfunction

    // Scoreboard of expected config writes, {addr, data}.
    logic [9:0] exp_q[$];

    always @(negedge clk) begin
        if (cfg_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL cfg_write: got write addr %0d data 0x%0h, required none",
                         cfg_addr, cfg_data);
            end else begin
                check("cfg_write", {cfg_addr, cfg_data}, exp_q.pop_front());
            end
        end
    end

    typedef struct {
        logic        div;
        logic        rep;
        logic [15:0] count;
        logic [7:0]  irqs;
        int          period;     // irq pulse spacing in MONITOR cycles (>= 2)
        int          set_delay;  // WAIT_SET cycles before counter_set; >= SET_TIMEOUT = never
        logic [7:0]  exp_cnt;
        logic [23:0] exp_period;
        logic        exp_err;
    } vec_t;

    vec_t vecs[6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accepts a command and checks the reset window; returns in the WR_CFG cycle.
    task automatic issue(input logic div, input logic rep, input logic [15:0] cnt,
                         input logic [7:0] irqs, input int n_writes);
        int w;
        logic [9:0] wr[3];
        w = 0;
        while (cmd_ready !== 1'b1 && w < 20) begin
            tick();
            w++;
        end
        check("cmd_ready_before_accept", cmd_ready, 1);
        cmd_divider = div;
        cmd_repeat  = rep;
        cmd_count   = cnt;
        cmd_irqs    = irqs;
        cmd_valid   = 1'b1;
        wr[0] = {2'b00, div, rep, 6'b000000};
        wr[1] = {2'b01, cnt[15:8]};
        wr[2] = {2'b10, cnt[7:0]};
        for (int i = 0; i < n_writes; i++) exp_q.push_back(wr[i]);
        tick();
        cmd_valid = 1'b0;
        for (int i = 0; i < int'(RST_CYCLES); i++) begin
            check("pit_rst_low", pit_rst_n, 0);
            check("busy_prst", busy, 1);
            tick();
        end
        check("cfg_we_at_wr_cfg", cfg_we, 1);
        check("pit_rst_high_at_wr_cfg", pit_rst_n, 1);
    endtask

    task automatic run_vec(input vec_t v);
        int t;
        int m;
        issue(v.div, v.rep, v.count, v.irqs, 3);
        tick();
        tick();
        tick();
        check("cfg_we_wait_set", cfg_we, 0);
        if (v.set_delay >= int'(SET_TIMEOUT)) begin
            t = 0;
            while (done !== 1'b1 && t < 100) begin
                tick();
                t++;
            end
            check("timeout_latency", t, SET_TIMEOUT);
        end else begin
            repeat (v.set_delay) tick();
            pit_counter_set = 1'b1;
            tick();
            m = 0;
            while (done !== 1'b1 && m < 500) begin
                pit_irq = ((m % v.period) == v.period - 1);
                tick();
                m++;
            end
            check("done_seen", done, 1);
        end
        pit_irq         = 1'b0;
        pit_counter_set = 1'b0;
        check("irq_count", irq_count, v.exp_cnt);
        check("last_period", last_period, v.exp_period);
        check("error", error, v.exp_err);
        check("busy_idle", busy, 0);
        check("cmd_ready_idle", cmd_ready, 1);
        tick();
        check("done_single_pulse", done, 0);
    endtask

    initial begin
        int dn;
        rst_n           = 1'b0;
        cmd_valid       = 1'b0;
        cmd_divider     = 1'b0;
        cmd_repeat      = 1'b0;
        cmd_count       = 16'h0000;
        cmd_irqs        = 8'h00;
        stop            = 1'b0;
        pit_counter_set = 1'b0;
        pit_irq         = 1'b0;

        //            div   rep   count     irqs  per dly  cnt    period  err
        vecs[0] = '{1'b1, 1'b1, 16'h1234, 8'd3, 10, 0,  8'd3, 24'd10, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 16'h00FF, 8'd1, 4,  3,  8'd1, 24'd4,  1'b0};
        vecs[2] = '{1'b1, 1'b0, 16'hABCD, 8'd2, 7,  14, 8'd2, 24'd7,  1'b0};
        vecs[3] = '{1'b0, 1'b0, 16'h0001, 8'd5, 3,  99, 8'd0, 24'd0,  1'b1};
        vecs[4] = '{1'b0, 1'b0, 16'h8000, 8'd2, 3,  1,  8'd2, 24'd3,  1'b0};
        vecs[5] = '{1'b1, 1'b1, 16'hFFFF, 8'd4, 2,  2,  8'd4, 24'd2,  1'b0};

        // Reset behaviour.
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_pit_rst_n", pit_rst_n, 0);
            check("rst_cmd_ready", cmd_ready, 0);
            check("rst_cfg", {cfg_we, cfg_addr, cfg_data}, 0);
            check("rst_status", {busy, done, error, irq_count}, 0);
            check("rst_last_period", last_period, 0);
        end
        rst_n = 1'b1;
        tick();
        check("post_rst_cmd_ready", cmd_ready, 1);
        check("post_rst_pit_rst_n", pit_rst_n, 1);

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // irqs=0 with irq held high, then 300 pulses, then stop.
        issue(1'b0, 1'b1, 16'h0005, 8'd0, 3);
        tick();
        tick();
        tick();
        pit_counter_set = 1'b1;
        tick();
        pit_irq = 1'b1;
        repeat (20) tick();
        check("held_irq_one_edge", irq_count, 1);
        pit_irq = 1'b0;
        tick();
        dn = 0;
        for (int i = 0; i < 300; i++) begin
            pit_irq = 1'b1;
            tick();
            dn += int'(done);
            pit_irq = 1'b0;
            tick();
            dn += int'(done);
        end
        check("irq_count_saturated", irq_count, 255);
        check("no_done_when_irqs0", dn, 0);
        check("last_period_2", last_period, 2);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        pit_counter_set = 1'b0;
        check("stop_done", done, 1);
        check("stop_busy", busy, 0);
        check("stop_cmd_ready", cmd_ready, 1);
        tick();
        check("stop_done_drop", done, 0);
        check("irq_count_held", irq_count, 255);

        // Stop together with the final edge: edge counted, one done.
        issue(1'b1, 1'b0, 16'h0010, 8'd1, 3);
        tick();
        tick();
        tick();
        pit_counter_set = 1'b1;
        tick();
        pit_irq = 1'b1;
        stop    = 1'b1;
        tick();
        pit_irq = 1'b0;
        stop    = 1'b0;
        pit_counter_set = 1'b0;
        check("stop_edge_done", done, 1);
        check("stop_edge_count", irq_count, 1);
        tick();
        check("stop_edge_single_done", done, 0);

        // Stop during PIT reset releases pit_rst_n.
        cmd_count = 16'h0042;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        check("prst_stop_low", pit_rst_n, 0);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("prst_stop_done", done, 1);
        check("prst_stop_pit_rst_n", pit_rst_n, 1);
        check("prst_stop_no_write", cfg_we, 0);

        // Reset in the WR_HI cycle.
        issue(1'b1, 1'b1, 16'hBEEF, 8'd1, 2);
        tick();
        check("wr_hi_cfg_we", cfg_we, 1);
        rst_n = 1'b0;
        tick();
        check("midrst_cfg_we", cfg_we, 0);
        check("midrst_pit_rst_n", pit_rst_n, 0);
        check("midrst_no_done", done, 0);
        rst_n = 1'b1;
        tick();
        check("midrst_ready", cmd_ready, 1);
        run_vec(vecs[0]);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
